pio_pulse_scheduler: RTL

//   Shares the single board output pin (pio48) between NUM_REQ requesters.

---
 rtl/pio_pulse_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pio_pulse_scheduler.sv
// pio_pulse_scheduler: round-robin arbiter that shares the pio48 pin between NUM_REQ pulse-train requesters
// Ports:
//   i_clk, i_rst   clock (rising edge), synchronous active-high reset
//   i_req_valid    per-requester request, held until accepted
//   i_req_high     per-requester high width in cycles, slice i = [i*CNT_W +: CNT_W]
//   i_req_low      per-requester low width in cycles, same slicing
//   i_req_reps     per-requester number of high/low periods, slice i = [i*REP_W +: REP_W]
//   o_req_ready    one-hot 1-cycle accept strobe, combinational, only in IDLE
//   o_grant        one-hot owner of the pin while its train plays
//   o_done         one-hot 1-cycle strobe on the first GAP cycle after a train
//   o_busy         high in any state except IDLE
//   o_pio          registered pin value
module pio_pulse_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int CNT_W      = 16,
    parameter int REP_W      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*CNT_W-1:0] i_req_high,
    input  logic [NUM_REQ*CNT_W-1:0] i_req_low,
    input  logic [NUM_REQ*REP_W-1:0] i_req_reps,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_busy,
    output logic                     o_pio
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t             r_state, w_state_nx;
    logic [PW-1:0]      r_ptr, w_ptr_nx, r_owner, w_owner_nx, w_sel, w_idx;
    logic               w_found;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx, r_high, w_high_nx, r_low, w_low_nx, w_h, w_l;
    logic [REP_W-1:0]   r_reps, w_reps_nx, w_r;
    logic               r_pio;
    logic [NUM_REQ-1:0] r_done, w_done_nx;

    // Round-robin search starting at r_ptr, then mux out the winner's fields
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_h     = '0;
        w_l     = '0;
        w_r     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_idx = PW'((int'(r_ptr) + j) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_sel == PW'(j)) begin
                w_h = i_req_high[j*CNT_W +: CNT_W];
                w_l = i_req_low[j*CNT_W +: CNT_W];
                w_r = i_req_reps[j*REP_W +: REP_W];
            end
        end
    end

    // r_high/r_low hold width-1 so the counters reload directly; a zero width behaves as 1
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_owner_nx = r_owner;
        w_cnt_nx   = r_cnt;
        w_high_nx  = r_high;
        w_low_nx   = r_low;
        w_reps_nx  = r_reps;
        case (r_state)
            IDLE: if (w_found) begin
                w_owner_nx = w_sel;
                w_ptr_nx   = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
                w_high_nx  = (w_h == '0) ? '0 : w_h - 1'b1;
                w_low_nx   = (w_l == '0) ? '0 : w_l - 1'b1;
                w_reps_nx  = w_r;
                w_state_nx = (w_r == '0) ? GAP : HIGH;
                w_cnt_nx   = (w_r == '0) ? GAP_LD : w_high_nx;
            end
            HIGH: if (r_cnt == '0) begin
                w_state_nx = LOW;
                w_cnt_nx   = r_low;
            end else begin
                w_cnt_nx = r_cnt - 1'b1;
            end
            LOW: if (r_cnt == '0) begin
                w_reps_nx  = r_reps - 1'b1;
                w_state_nx = (r_reps == REP_W'(1)) ? GAP : HIGH;
                w_cnt_nx   = (r_reps == REP_W'(1)) ? GAP_LD : r_high;
            end else begin
                w_cnt_nx = r_cnt - 1'b1;
            end
            GAP: if (r_cnt == '0) begin
                w_state_nx = IDLE;
            end else begin
                w_cnt_nx = r_cnt - 1'b1;
            end
            default: w_state_nx = IDLE;
        endcase
        // done lands on the first GAP cycle, including the reps=0 shortcut from IDLE
        w_done_nx = (w_state_nx == GAP && r_state != GAP) ? NUM_REQ'(1) << w_owner_nx : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_high  <= '0;
            r_low   <= '0;
            r_reps  <= '0;
            r_pio   <= 1'b0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_owner <= w_owner_nx;
            r_cnt   <= w_cnt_nx;
            r_high  <= w_high_nx;
            r_low   <= w_low_nx;
            r_reps  <= w_reps_nx;
            r_pio   <= (w_state_nx == HIGH);
            r_done  <= w_done_nx;
        end
    end

    assign o_req_ready = (r_state == IDLE && w_found) ? NUM_REQ'(1) << w_sel : '0;
    assign o_grant     = (r_state == HIGH || r_state == LOW) ? NUM_REQ'(1) << r_owner : '0;
    assign o_done      = r_done;
    assign o_busy      = (r_state != IDLE);
    assign o_pio       = r_pio;
endmodule
